bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with registered one-hot grant and source select.
// Optional forced release after HOLD_MAX grant cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int SEL_W    = 5,
  parameter int HOLD_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*SEL_W-1:0]      req_sel,
  input  logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            gnt,
  output logic [SEL_W-1:0]           read_en,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy,
  output logic                       sel_err,
  output logic                       timeout
);

  localparam int OWN_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [SEL_W-1:0]   read_en_nxt;
  logic [OWN_W-1:0]   owner_nxt;
  logic               busy_nxt;
  logic               sel_err_nxt;
  logic [OWN_W-1:0]   last_owner, last_owner_nxt;
  logic [OWN_W-1:0]   winner;
  logic [SEL_W-1:0]   win_sel;
  logic               hold_hit;
  logic [SEL_W-1:0]   sel_arr [NREQ];

  // Search order starts one past the previous owner; the previous owner itself is last.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [OWN_W-1:0] last);
    logic [OWN_W-1:0] idx;
    rr_pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OWN_W'((int'(last) + k) % NREQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic sel_legal(input logic [SEL_W-1:0] s);
    sel_legal = (s >= SEL_W'(1)) && (s <= SEL_W'(17));
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
  end

  assign winner  = rr_pick(req, last_owner);
  assign win_sel = sel_arr[winner];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] hold_cnt;

  // Counter sits at zero outside GRANT, so every grant starts counting from a clean value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               hold_cnt <= '0;
    else if (state == GRANT)  hold_cnt <= hold_cnt + CNT_W'(1);
    else                      hold_cnt <= '0;
  end

  assign hold_hit = (state == GRANT) && (hold_cnt == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout <= 1'b0;
    else        timeout <= hold_hit;
  end
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    read_en_nxt    = read_en;
    owner_nxt      = owner;
    busy_nxt       = busy;
    sel_err_nxt    = 1'b0;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        gnt_nxt     = '0;
        read_en_nxt = '0;
        busy_nxt    = 1'b0;
        if (|req) begin
          state_nxt   = GRANT;
          gnt_nxt     = NREQ'(1) << winner;
          owner_nxt   = winner;
          busy_nxt    = 1'b1;
          read_en_nxt = sel_legal(win_sel) ? win_sel : '0;
          sel_err_nxt = !sel_legal(win_sel);
        end
      end
      GRANT: begin
        // Only the owner's done/req matter; read_en is left untouched until release.
        if (done[owner] || !req[owner] || hold_hit) begin
          state_nxt      = TURN;
          gnt_nxt        = '0;
          read_en_nxt    = '0;
          busy_nxt       = 1'b0;
          last_owner_nxt = owner;
        end
      end
      TURN: begin
        state_nxt   = IDLE;
        gnt_nxt     = '0;
        read_en_nxt = '0;
        busy_nxt    = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        gnt_nxt     = '0;
        read_en_nxt = '0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      read_en    <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      sel_err    <= 1'b0;
      last_owner <= OWN_W'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      read_en    <= read_en_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      sel_err    <= sel_err_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter; the timeout scenario follows BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [19:0] req_sel;
  logic [3:0]  done;
  logic [3:0]  gnt;
  logic [4:0]  read_en;
  logic [1:0]  owner;
  logic        busy;
  logic        sel_err;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.NREQ(4), .SEL_W(5), .HOLD_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .done(done),
    .gnt(gnt), .read_en(read_en), .owner(owner), .busy(busy),
    .sel_err(sel_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; req_sel = 20'd6;
    tick();
    tick();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0000", gnt); end
    n_tests++; if (read_en !== 5'd0) begin n_fail++; $display("FAIL rst_read_en: got %0d exp 0", read_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL rst_owner: got %0d exp 0", owner); end
    n_tests++; if ({sel_err, timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b exp 00", {sel_err, timeout}); end
    rst_n = 1'b1; req = '0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_grant();
    req = 4'b0001; req_sel = '0; req_sel[4:0] = 5'd6; done = 4'b0001;
    tick();
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b exp 0001", gnt); end
    n_tests++; if (read_en !== 5'd6) begin n_fail++; $display("FAIL single_read_en: got %0d exp 6", read_en); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL single_sel_err: got %b exp 0", sel_err); end
    done = 4'b0000;
    tick();
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL issue_done_ignored: got %b exp 0001", gnt); end
    done = 4'b0001;
    tick();
    n_tests++; if ({gnt, read_en, busy} !== 10'd0) begin n_fail++; $display("FAIL single_turn: got gnt=%b rd=%0d busy=%b exp all 0", gnt, read_en, busy); end
    done = 4'b0000; req = 4'b0000;
    tick();
    n_tests++; if ({gnt, busy} !== 5'd0) begin n_fail++; $display("FAIL single_idle: got gnt=%b busy=%b exp 0", gnt, busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_gnt;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_sel[5*i +: 5] = 5'(i + 2);
    for (int g = 0; g < 8; g++) begin
      e_gnt = 4'b0001 << (g % 4);
      tick();
      n_tests++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b exp %b", g, gnt, e_gnt); end
      n_tests++; if (owner !== 2'(g % 4)) begin n_fail++; $display("FAIL b2b_owner[%0d]: got %0d exp %0d", g, owner, g % 4); end
      n_tests++; if (read_en !== 5'((g % 4) + 2)) begin n_fail++; $display("FAIL b2b_read_en[%0d]: got %0d exp %0d", g, read_en, (g % 4) + 2); end
      done = e_gnt;
      tick();
      n_tests++; if ({gnt, read_en, busy} !== 10'd0) begin n_fail++; $display("FAIL b2b_turn[%0d]: got gnt=%b rd=%0d busy=%b exp 0", g, gnt, read_en, busy); end
      done = 4'b0000;
      tick();
      n_tests++; if ({gnt, busy} !== 5'd0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got gnt=%b busy=%b exp 0", g, gnt, busy); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_sel_codes();
    logic [4:0] sels  [5] = '{5'd0, 5'd20, 5'd17, 5'd1, 5'd18};
    logic [4:0] e_rd  [5] = '{5'd0, 5'd0,  5'd17, 5'd1, 5'd0};
    logic       e_err [5] = '{1'b1, 1'b1,  1'b0,  1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      req_sel[14:10] = sels[k]; req = 4'b0100;
      tick();
      n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sel_gnt[%0d]: got %b exp 0100", k, gnt); end
      n_tests++; if (read_en !== e_rd[k]) begin n_fail++; $display("FAIL sel_read_en[%0d]: got %0d exp %0d", k, read_en, e_rd[k]); end
      n_tests++; if (sel_err !== e_err[k]) begin n_fail++; $display("FAIL sel_err_first[%0d]: got %b exp %b", k, sel_err, e_err[k]); end
      tick();
      n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_pulse[%0d]: got %b exp 0", k, sel_err); end
      n_tests++; if (read_en !== e_rd[k]) begin n_fail++; $display("FAIL sel_read_en_hold[%0d]: got %0d exp %0d", k, read_en, e_rd[k]); end
      req = 4'b0000;
      tick();
      n_tests++; if ({read_en, busy} !== 6'd0) begin n_fail++; $display("FAIL sel_turn[%0d]: got rd=%0d busy=%b exp 0", k, read_en, busy); end
      tick();
    end
  endtask

  task automatic test_hold_stable();
    req = 4'b0010; req_sel[9:5] = 5'd9;
    tick();
    n_tests++; if ({gnt, read_en} !== {4'b0010, 5'd9}) begin n_fail++; $display("FAIL hold_start: got gnt=%b rd=%0d exp 0010/9", gnt, read_en); end
    req_sel[9:5] = 5'd3; done = 4'b0100; req = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++; if ({gnt, read_en, busy} !== {4'b0010, 5'd9, 1'b1}) begin n_fail++; $display("FAIL hold_stable[%0d]: got gnt=%b rd=%0d busy=%b exp 0010/9/1", c, gnt, read_en, busy); end
    end
    done = 4'b0010;
    tick();
    n_tests++; if ({gnt, busy} !== 5'd0) begin n_fail++; $display("FAIL hold_release: got gnt=%b busy=%b exp 0", gnt, busy); end
    done = 4'b0000; req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010; req_sel[9:5] = 5'd9;
    tick();
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_setup: got %b exp 0010", gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({gnt, read_en, busy} !== 10'd0) begin n_fail++; $display("FAIL midrst_async: got gnt=%b rd=%0d busy=%b exp 0", gnt, read_en, busy); end
    req = 4'b1000;
    tick();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_held: got %b exp 0000", gnt); end
    rst_n = 1'b1;
    tick();
    n_tests++; if ({gnt, owner} !== {4'b1000, 2'd3}) begin n_fail++; $display("FAIL midrst_after: got gnt=%b owner=%0d exp 1000/3", gnt, owner); end
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b0011;
    tick();
    n_tests++; if ({gnt, owner} !== {4'b0001, 2'd0}) begin n_fail++; $display("FAIL rst_search_from0: got gnt=%b owner=%0d exp 0001/0", gnt, owner); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    int seen_to;
    cnt = 0; seen_to = 0;
    do_reset();
    req = 4'b0001; req_sel[4:0] = 5'd6;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt == 4'b0001) begin
        cnt++;
        if (timeout) seen_to++;
      end else if (cnt > 0) begin
        break;
      end
    end
    n_tests++; if (cnt !== 16) begin n_fail++; $display("FAIL to_grant_len: got %0d exp 16", cnt); end
    n_tests++; if (seen_to !== 0) begin n_fail++; $display("FAIL to_early: got %0d pulses exp 0", seen_to); end
    n_tests++; if ({timeout, gnt} !== 5'b10000) begin n_fail++; $display("FAIL to_pulse: got to=%b gnt=%b exp 1/0000", timeout, gnt); end
    tick();
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %b exp 0", timeout); end
`else
    for (int c = 0; c < 120; c++) begin
      tick();
      if (gnt == 4'b0001) cnt++;
      if (timeout) seen_to++;
    end
    n_tests++; if (cnt !== 120) begin n_fail++; $display("FAIL nto_grant_len: got %0d exp 120", cnt); end
    n_tests++; if (seen_to !== 0) begin n_fail++; $display("FAIL nto_timeout: got %0d pulses exp 0", seen_to); end
`endif
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; req = '0; req_sel = '0; done = '0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_sel_codes();
    test_hold_stable();
    test_reset_mid_grant();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
